kitchen_timer_ctrl: RTL

//  Control FSM for the kitchen-timer countdown datapath (mm:ss BCD digit registers).

---
 rtl/kitchen_timer_pkg.sv | 36 +++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/kitchen_timer_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/kitchen_timer_pkg.sv
// Shared types and helpers for the kitchen-timer control slice:
// state encoding, BCD set-point limits and the BCD increment helper.
package kitchen_timer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SET   = S_SET,
    ST_RUN   = S_RUN,
    ST_PAUSE = S_PAUSE,
    ST_ALARM = S_ALARM
  } state_e;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h99;

  // Two-digit BCD increment; the value at the limit wraps to 00 so a field
  // never carries into its neighbour.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] limit);
    logic [7:0] res;
    if (val == limit) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to the countdown tick. The counter holds when en is low,
// clr restarts it from zero and wins over en. tick flags the last count of
// an enabled cycle so the owner can register it as a one-cycle strobe.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clr, advance and wrap when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen-timer control FSM: owns the mm:ss BCD set-point, loads it into the
// countdown datapath, gates the decrement strobe, handles pause/resume and
// holds the alarm for a bounded number of ticks.
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       cnt_zero,
  output logic       load,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic       tick_en,
  output logic       running,
  output logic       paused,
  output logic       alarm
);

  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_e        state_q, state_d;
  logic [7:0]    set_min_q, set_min_d;
  logic [7:0]    set_sec_q, set_sec_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          load_q, load_d;
  logic          tick_en_q, tick_en_d;
  logic          running_q, paused_q, alarm_q;
  logic          pre_en, pre_clr, pre_tick;
  logic          set_nonzero, zero_seen, start_ok;

  assign set_nonzero = (set_min_q != 8'h00) || (set_sec_q != 8'h00);
  // The load cycle still shows the datapath's old value, so 00:00 is ignored there.
  assign zero_seen   = cnt_zero && !load_q;
  assign start_ok    = btn_start && set_nonzero;

  // Prescaler control: restart on load or alarm entry, count while RUN
  // persists, free-run in ALARM, freeze everywhere else.
  always_comb begin
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SET: pre_clr = start_ok;
      ST_RUN: begin
        pre_clr = zero_seen;
        pre_en  = !zero_seen && !btn_start;
      end
      ST_ALARM: pre_en = 1'b1;
      default: ;
    endcase
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK   (CLK),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_tick)
  );

  // Next state, set-point edits, alarm counter and output pulses.
  always_comb begin
    state_d     = state_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    alarm_cnt_d = alarm_cnt_q;
    load_d      = 1'b0;
    tick_en_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SET: begin
        if (start_ok) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (btn_min || btn_sec) begin
          state_d = ST_SET;
          if (btn_min) set_min_d = bcd_inc(set_min_q, MIN_MAX);
          if (btn_sec) set_sec_d = bcd_inc(set_sec_q, SEC_MAX);
        end
      end
      ST_RUN: begin
        tick_en_d = pre_tick;
        if (zero_seen) begin
          state_d     = ST_ALARM;
          alarm_cnt_d = '0;
        end else if (btn_start) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_start) state_d = ST_RUN;
      end
      ST_ALARM: begin
        if (btn_start || btn_min || btn_sec) begin
          state_d = ST_IDLE;
        end else if (pre_tick) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            state_d = ST_IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, set-point and registered outputs; reset clears everything.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      set_min_q   <= 8'h00;
      set_sec_q   <= 8'h00;
      alarm_cnt_q <= '0;
      load_q      <= 1'b0;
      tick_en_q   <= 1'b0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      alarm_cnt_q <= alarm_cnt_d;
      load_q      <= load_d;
      tick_en_q   <= tick_en_d;
      running_q   <= (state_d == ST_RUN);
      paused_q    <= (state_d == ST_PAUSE);
      alarm_q     <= (state_d == ST_ALARM);
    end
  end

  assign load    = load_q;
  assign set_min = set_min_q;
  assign set_sec = set_sec_q;
  assign tick_en = tick_en_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign alarm   = alarm_q;

endmodule
